sqrt_f32_arbiter: RTL and testbench

//  Shares one f32 square-root unit (start/rdy handshake) among NREQ processing elements.

---
 rtl/sqrt_f32_arbiter_pkg.sv | 19 +
 rtl/sqrt_f32_arbiter_if.sv | 29 ++
 rtl/sqrt_f32_arbiter_rr.sv | 31 +++
 rtl/sqrt_f32_arbiter.sv | 119 +++++++++++
 tb/tb_sqrt_f32_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sqrt_f32_arbiter_pkg.sv
// Shared types and constants for the f32 square-root sharing controller.
package sqrt_arb_pkg;

  localparam int F32_W = 32;
  localparam logic [F32_W-1:0] F32_QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Width of a requester index; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sqrt_f32_arbiter_if.sv
// Request/response and unit-side signals of the shared square-root controller.
// Handshake: a requester holds req_valid/req_a until its one-cycle req_ready pulse;
// resp_valid is a one-cycle pulse with no backpressure; the unit sees a one-cycle
// unit_start and answers with unit_rdy/unit_sqrt some cycles later.
interface sqrt_f32_arbiter_if #(parameter int NREQ = 4);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    resp_valid;
  logic [31:0]        resp_data;
  logic               resp_err;
  logic               unit_start;
  logic [31:0]        unit_a;
  logic               unit_rdy;
  logic [31:0]        unit_sqrt;

  // master: PE array plus the square-root unit; slave: the controller
  modport master (
    output req_valid, req_a, unit_rdy, unit_sqrt,
    input  req_ready, resp_valid, resp_data, resp_err, unit_start, unit_a
  );

  modport slave (
    input  req_valid, req_a, unit_rdy, unit_sqrt,
    output req_ready, resp_valid, resp_data, resp_err, unit_start, unit_a
  );

endinterface

// File: rtl/sqrt_f32_arbiter_rr.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter_n
  import sqrt_arb_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IW  = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!any && req[j[IW-1:0]]) begin
        any             = 1'b1;
        idx             = j[IW-1:0];
        grant[j[IW-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sqrt_f32_arbiter.sv
// Shares one f32 square-root unit among NREQ requesters in round-robin order.
// Optional watchdog on the unit wait is built when SQRT_ARB_TIMEOUT_EN is defined.
module sqrt_f32_arbiter
  import sqrt_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  sqrt_f32_arbiter_if.slave   bus,
  output logic                busy,
  output state_t              dbg_state
);

  localparam int IW = idx_w(NREQ);

  state_t           state, state_nx;
  logic [IW-1:0]    ptr, gidx, arb_idx;
  logic [NREQ-1:0]  arb_grant;
  logic             arb_any;
  logic [F32_W-1:0] op_q, res_q, sel_a;
  logic             first_q, sel_zero, unit_done, expired;

  rr_arbiter_n #(.NREQ(NREQ)) u_arb (
    .req   (bus.req_valid),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  always_comb begin
    sel_a = '0;
    for (int k = 0; k < NREQ; k++)
      if (arb_idx == IW'(k)) sel_a = bus.req_a[k*F32_W +: F32_W];
  end

  assign sel_zero  = (sel_a[F32_W-2:0] == '0);
  // The unit drops rdy only after seeing start, so the first WAIT cycle is stale.
  assign unit_done = (state == WAIT) && !first_q && bus.unit_rdy;

`ifdef SQRT_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  logic          err_q;

  assign expired = (state == WAIT) && (cnt == CW'(TIMEOUT)) && !unit_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == START)     cnt <= '0;
      else if (state == WAIT) cnt <= cnt + 1'b1;
      if (state == IDLE && arb_any) err_q <= 1'b0;
      else if (expired)             err_q <= 1'b1;
    end
  end

  assign bus.resp_err = (state == RESP) ? err_q : 1'b0;
`else
  assign expired      = 1'b0;
  assign bus.resp_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (arb_any) state_nx = sel_zero ? RESP : START;
      START:   state_nx = WAIT;
      WAIT:    if (unit_done || expired) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr     <= '0;
      gidx    <= '0;
      op_q    <= '0;
      res_q   <= '0;
      first_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (arb_any) begin
          gidx <= arb_idx;
          op_q <= sel_a;
          if (sel_zero) res_q <= sel_a;
        end
        START: first_q <= 1'b1;
        WAIT: begin
          first_q <= 1'b0;
          if (unit_done)    res_q <= bus.unit_sqrt;
          else if (expired) res_q <= F32_QNAN;
        end
        RESP:    ptr <= (gidx == IW'(NREQ - 1)) ? '0 : gidx + 1'b1;
        default: ;
      endcase
    end
  end

  // Grant is gated by rst so outputs are quiet during an asynchronous reset.
  assign bus.req_ready  = (state == IDLE && !rst) ? arb_grant : '0;
  assign bus.resp_valid = (state == RESP) ? (NREQ'(1) << gidx) : '0;
  assign bus.resp_data  = res_q;
  assign bus.unit_start = (state == START);
  assign bus.unit_a     = op_q;
  assign busy           = (state != IDLE);
  assign dbg_state      = state;

endmodule

// File: tb/tb_sqrt_f32_arbiter.sv
// Bench for sqrt_f32_arbiter: directed requests, a reactive unit model and a cycle-level scoreboard.
module tb_sqrt_f32_arbiter;
  import sqrt_arb_pkg::*;

  localparam int NR = 4;
  localparam int TO = 8;
  localparam int EW = 37;

  logic   clk = 1'b0;
  logic   rst;
  logic   busy;
  state_t dbg_state;

  sqrt_f32_arbiter_if #(.NREQ(NR)) bus ();

  sqrt_f32_arbiter #(.NREQ(NR), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial forever #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int vectors = 0;
  int miscompares = 0;

  logic [31:0]   pend [NR][$];
  logic [EW-1:0] exp_q[$];

  int unit_lat = 3;
  bit unit_stale = 0;
  bit unit_never = 0;
  int rdy_cyc = -1;

  bit          m_out = 0;
  int          m_own, m_t;
  logic [31:0] m_op;
  bit          m_byp, m_never;
  int          mptr = 0;
  int          idle_from = 0;

  int          grant_log[$];
  int          resp_log[$];
  logic [31:0] last_data;
  logic        last_err;
  int          last_grant_cyc, last_start_cyc, last_resp_cyc;
  int          start_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Square roots of the operands used below; anything else gets an arbitrary pattern.
  function automatic logic [31:0] sqrt_ref(input logic [31:0] a);
    case (a)
      32'h40800000: return 32'h40000000;
      32'h41100000: return 32'h40400000;
      32'h3F800000: return 32'h3F800000;
      32'h41800000: return 32'h40800000;
      32'h42C80000: return 32'h41200000;
      32'hBF800000: return 32'h7FC00000;
      default:      return a ^ 32'h5A5A5A5A;
    endcase
  endfunction

  function automatic int rr_pick(input logic [NR-1:0] v, input int p);
    for (int k = 0; k < NR; k++)
      if (v[(p + k) % NR]) return (p + k) % NR;
    return -1;
  endfunction

  function automatic bit pend_empty();
    for (int i = 0; i < NR; i++) if (pend[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic sync();
    @(negedge clk);
    #2;
  endtask

  task automatic push(input int i, input logic [31:0] a);
    pend[i].push_back(a);
  endtask

  task automatic wait_done(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      #1;
      if (!m_out && pend_empty()) begin
        ok = 1'b1;
        break;
      end
    end
    chk({name, "_done"}, ok, 1);
    @(negedge clk);
    #1;
  endtask

  logic [NR-1:0] drv_snap;
  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    forever begin
      @(negedge clk);
      drv_snap = bus.req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (drv_snap[i] && pend[i].size() > 0) void'(pend[i].pop_front());
        bus.req_valid[i]      = (pend[i].size() > 0);
        bus.req_a[32*i +: 32] = (pend[i].size() > 0) ? pend[i][0] : 32'h0;
      end
    end
  end

  // Square-root unit: answers a start after unit_lat cycles, optionally with a stale rdy first.
  logic [31:0] u_a;
  int          u_lat;
  bit          u_stale, u_never;
  initial begin
    bus.unit_rdy  = 1'b0;
    bus.unit_sqrt = '0;
    forever begin
      @(negedge clk);
      if (bus.unit_start === 1'b1 && !rst) begin
        u_a = bus.unit_a;
        u_lat = unit_lat;
        u_stale = unit_stale;
        u_never = unit_never;
        if (!u_never) begin
          for (int c = 1; c <= u_lat; c++) begin
            @(posedge clk);
            #1;
            if (rst) break;
            bus.unit_rdy  = (c == u_lat) || (u_stale && c == 1);
            bus.unit_sqrt = (c == u_lat) ? sqrt_ref(u_a) : 32'hDEADBEEF;
            if (c == u_lat) rdy_cyc = cyc;
          end
        end
        @(posedge clk);
        #1;
        bus.unit_rdy = 1'b0;
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  int            c_g, c_obs;
  bit            c_due, c_err;
  logic [NR-1:0] c_exp_rr, c_exp_rv;
  logic [31:0]   c_data;
  logic [EW-1:0] c_e;
  initial forever begin
    @(negedge clk);
    if (rst) begin
      m_out = 1'b0;
      mptr = 0;
      exp_q.delete();
      idle_from = cyc + 1;
    end else begin
      chk("busy", busy, m_out && cyc > m_t);

      chk("unit_start", bus.unit_start, m_out && !m_byp && cyc == m_t + 1);
      if (bus.unit_start === 1'b1) begin
        start_cnt++;
        last_start_cyc = cyc;
        chk("unit_a", bus.unit_a, m_op);
      end

      c_due = m_out && ((m_byp && cyc == m_t + 1) ||
                        (!m_byp && m_never && cyc == m_t + 3 + TO) ||
                        (!m_byp && !m_never && rdy_cyc >= 0 && cyc == rdy_cyc + 1));
      c_exp_rv = c_due ? (NR'(1) << m_own) : '0;
      chk("resp_valid", bus.resp_valid, c_exp_rv);
      if (bus.resp_valid != '0) begin
        c_obs = -1;
        for (int k = 0; k < NR; k++) if (bus.resp_valid[k]) c_obs = k;
        resp_log.push_back(c_obs);
        last_data = bus.resp_data;
        last_err = bus.resp_err;
        last_resp_cyc = cyc;
      end
      if (c_due) begin
        c_e = exp_q.pop_front();
        chk("resp_data", bus.resp_data, c_e[31:0]);
        chk("resp_err", bus.resp_err, c_e[32]);
        m_out = 1'b0;
        mptr = (m_own + 1) % NR;
        idle_from = cyc + 1;
      end

      c_g = (!m_out && cyc >= idle_from) ? rr_pick(bus.req_valid, mptr) : -1;
      c_exp_rr = (c_g >= 0) ? (NR'(1) << c_g) : '0;
      chk("req_ready", bus.req_ready, c_exp_rr);
      if (bus.req_ready != '0) begin
        c_obs = -1;
        for (int k = 0; k < NR; k++) if (bus.req_ready[k]) c_obs = k;
        grant_log.push_back(c_obs);
        last_grant_cyc = cyc;
      end
      if (c_g >= 0) begin
        m_out = 1'b1;
        m_own = c_g;
        m_t = cyc;
        m_op = pend[c_g][0];
        m_byp = (m_op[30:0] == 31'd0);
        m_never = unit_never;
        rdy_cyc = -1;
        c_err = m_never && !m_byp;
        c_data = m_byp ? m_op : (m_never ? 32'h7FC00000 : sqrt_ref(m_op));
        exp_q.push_back({4'(m_own), c_err, c_data});
      end
    end
  end

  // ---------------- directed tests ----------------
  int exp_t2[8] = '{1, 2, 3, 0, 1, 2, 3, 0};
  int s0;

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_resp_data", bus.resp_data, 0);
    chk("rst_unit_a", bus.unit_a, 0);
    chk("rst_state", dbg_state, IDLE);
    @(posedge clk);
    #2 rst = 1'b0;

    // single request, unit answers 5 cycles after start
    unit_lat = 5;
    sync(); push(0, 32'h40800000);
    wait_done("t1");
    chk("t1_data", last_data, 32'h40000000);
    chk("t1_err", last_err, 0);
    chk("t1_start_lat", last_start_cyc - last_grant_cyc, 1);
    chk("t1_resp_lat", last_resp_cyc - last_grant_cyc, 7);

    // every requester valid back to back; pointer starts at 1 after t1
    unit_lat = 2;
    grant_log.delete(); resp_log.delete();
    sync();
    push(0, 32'h41100000); push(0, 32'h3F800000);
    push(1, 32'h41800000); push(1, 32'h42C80000);
    push(2, 32'h40800000); push(2, 32'h3F800000);
    push(3, 32'h42C80000); push(3, 32'h41100000);
    wait_done("t2");
    chk("t2_grants", grant_log.size(), 8);
    chk("t2_resps", resp_log.size(), 8);
    for (int k = 0; k < 8 && k < grant_log.size() && k < resp_log.size(); k++) begin
      chk("t2_grant_order", grant_log[k], exp_t2[k]);
      chk("t2_resp_owner", resp_log[k], exp_t2[k]);
    end

    // zero bypass and a negative operand sent to the unit
    s0 = start_cnt;
    sync(); push(2, 32'h80000000);
    wait_done("t3a");
    chk("t3_data", last_data, 32'h80000000);
    chk("t3_resp_lat", last_resp_cyc - last_grant_cyc, 1);
    chk("t3_no_start", start_cnt - s0, 0);
    sync(); push(3, 32'hBF800000);
    wait_done("t3b");
    chk("t3_neg_data", last_data, 32'h7FC00000);
    chk("t3_neg_err", last_err, 0);
    sync(); push(0, 32'h00000000);
    wait_done("t3c");
    chk("t3_pz_lat", last_resp_cyc - last_grant_cyc, 1);

    // stale rdy in the first WAIT cycle, real result three cycles later
    unit_lat = 4; unit_stale = 1'b1;
    sync(); push(1, 32'h41100000);
    wait_done("t4");
    unit_stale = 1'b0;
    chk("t4_data", last_data, 32'h40400000);
    chk("t4_resp_lat", last_resp_cyc - last_grant_cyc, 6);

    // reset while waiting on the unit
    unit_lat = 10;
    sync(); push(3, 32'h41800000);
    for (int i = 0; i < 20 && !m_out; i++) begin
      @(negedge clk);
      #1;
    end
    chk("t5_granted", m_out, 1);
    push(1, 32'h3F800000); push(2, 32'h41100000);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t5_req_ready", bus.req_ready, 0);
    chk("t5_resp_valid", bus.resp_valid, 0);
    chk("t5_resp_data", bus.resp_data, 0);
    chk("t5_resp_err", bus.resp_err, 0);
    chk("t5_unit_start", bus.unit_start, 0);
    chk("t5_unit_a", bus.unit_a, 0);
    chk("t5_busy", busy, 0);
    grant_log.delete(); resp_log.delete();
    unit_lat = 3;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    wait_done("t5");
    chk("t5_grants", grant_log.size(), 2);
    chk("t5_resps", resp_log.size(), 2);
    if (grant_log.size() == 2 && resp_log.size() == 2) begin
      chk("t5_first_grant", grant_log[0], 1);
      chk("t5_second_grant", grant_log[1], 2);
      chk("t5_first_resp", resp_log[0], 1);
    end

`ifdef SQRT_ARB_TIMEOUT_EN
    // unit never answers: watchdog result, then a normal operation
    unit_never = 1'b1;
    sync(); push(0, 32'h41100000);
    wait_done("t6a");
    unit_never = 1'b0;
    chk("t6_data", last_data, 32'h7FC00000);
    chk("t6_err", last_err, 1);
    chk("t6_resp_lat", last_resp_cyc - last_grant_cyc, 3 + TO);
    sync(); push(2, 32'h3F800000);
    wait_done("t6b");
    chk("t6_next_data", last_data, 32'h3F800000);
    chk("t6_next_err", last_err, 0);
`endif

    // ---------------- final report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    miscompares++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
